// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants: default widths and architectural register indices.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_RA   = 31;
  localparam int unsigned LINK_REG = REG_RA;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issued loads, cleared by commits or flush.
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_addr,
  input  logic [2**ADDR_W-1:0]   clr_vec,
  input  logic                   flush,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pend_count
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [Depth-1:0] pend_d, pend_q;
  logic [ADDR_W:0]  count_d, count_q;

  // Priority: flush > set > clear, register 0 never pending.
  always_comb begin
    pend_d = pend_q & ~clr_vec;
    if (pend_set && (pend_addr != ADDR_W'(REG_ZERO))) begin
      pend_d[pend_addr] = 1'b1;
    end
    if (flush) begin
      pend_d = '0;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < Depth; i++) begin
      count_d = count_d + (ADDR_W+1)'(pend_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
    end
  end

  assign pend       = pend_q;
  assign pend_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file with link write port, optional write-to-read bypass and busy flags.
module regfile_sb
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LINK_REG = mips_pkg::LINK_REG,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              ra_we,
  input  logic [DATA_W-1:0] ra_data,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pend_count
);

  localparam int unsigned       Depth    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);
  localparam bit                BypassEn = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [Depth];
  logic              wb_eff, ra_eff;
  logic [Depth-1:0]  clr_vec, pend;
  logic              rs_hit, rt_hit;

  // The link port wins a collision on LINK_REG; the writeback is dropped.
  assign ra_eff = ra_we && (LinkAddr != ZeroAddr);
  assign wb_eff = we && (rd_addr != ZeroAddr) && !(ra_eff && (rd_addr == LinkAddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wb_eff) regs_q[rd_addr] <= rd_data;
      if (ra_eff) regs_q[LinkAddr] <= ra_data;
    end
  end

  always_comb begin
    clr_vec = '0;
    if (wb_eff) clr_vec[rd_addr] = 1'b1;
    if (ra_eff) clr_vec[LinkAddr] = 1'b1;
  end

  assign rs_hit = (wb_eff && (rd_addr == rs_addr)) || (ra_eff && (LinkAddr == rs_addr));
  assign rt_hit = (wb_eff && (rd_addr == rt_addr)) || (ra_eff && (LinkAddr == rt_addr));

  // Link data is applied last so it takes priority, mirroring the commit rule.
  always_comb begin
    rs_data = (rs_addr == ZeroAddr) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == ZeroAddr) ? '0 : regs_q[rt_addr];
    if (BypassEn) begin
      if (wb_eff && (rd_addr == rs_addr)) rs_data = rd_data;
      if (wb_eff && (rd_addr == rt_addr)) rt_data = rd_data;
      if (ra_eff && (LinkAddr == rs_addr)) rs_data = ra_data;
      if (ra_eff && (LinkAddr == rt_addr)) rt_data = ra_data;
    end
  end

  assign rs_busy = pend[rs_addr] && !(BypassEn && rs_hit);
  assign rt_busy = pend[rt_addr] && !(BypassEn && rt_hit);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .pend_set   (pend_set),
    .pend_addr  (pend_addr),
    .clr_vec    (clr_vec),
    .flush      (flush),
    .pend       (pend),
    .pend_count (pend_count)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: bypass and non-bypass instances driven in parallel.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, rd_addr, pend_addr;
  logic [31:0] rd_data, ra_data;
  logic        we, ra_we, pend_set, flush;

  logic [31:0] rs_data, rt_data, nb_rs_data, nb_rt_data;
  logic        rs_busy, rt_busy, nb_rs_busy, nb_rt_busy;
  logic [5:0]  pend_count, nb_pend_count;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .ra_we(ra_we), .ra_data(ra_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .flush(flush), .pend_count(pend_count)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(nb_rs_data), .rt_data(nb_rt_data), .rs_busy(nb_rs_busy), .rt_busy(nb_rt_busy),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .ra_we(ra_we), .ra_data(ra_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .flush(flush), .pend_count(nb_pend_count)
  );

  typedef enum int {SRsData, SRtData, SRsBusy, SRtBusy, SCount,
                    SNbRsData, SNbRtData, SNbRtBusy, SNbCount} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: outputs are sampled on the falling edge, mid-way through each driven cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.sel)
        SRsData:   act = rs_data;
        SRtData:   act = rt_data;
        SRsBusy:   act = {31'b0, rs_busy};
        SRtBusy:   act = {31'b0, rt_busy};
        SCount:    act = {26'b0, pend_count};
        SNbRsData: act = nb_rs_data;
        SNbRtData: act = nb_rt_data;
        SNbRtBusy: act = {31'b0, nb_rt_busy};
        default:   act = {26'b0, nb_pend_count};
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
      end
    end
  end

  function automatic void expect_val(string n, sel_e s, logic [31:0] e);
    chk_t c;
    c.name = n;
    c.sel  = s;
    c.exp  = e;
    q.push_back(c);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    we = 1'b0; ra_we = 1'b0; pend_set = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rs_addr = '0; rt_addr = '0; rd_addr = '0; pend_addr = '0;
    rd_data = '0; ra_data = '0; we = 1'b0; ra_we = 1'b0; pend_set = 1'b0; flush = 1'b0;
    #1;
    expect_val("reset_rs0", SRsData, 32'h0);
    expect_val("reset_count", SCount, 32'h0);
    expect_val("reset_busy", SRsBusy, 32'h0);

    next_cycle(); rst_n = 1'b1;
    // Write R5 then check bypass vs stored value.
    next_cycle(); we = 1'b1; rd_addr = 5'd5; rd_data = 32'h1234; rs_addr = 5'd5;
    expect_val("r5_bypass", SRsData, 32'h1234);
    expect_val("r5_nb_old", SNbRsData, 32'h0);
    next_cycle();
    expect_val("r5_stored", SRsData, 32'h1234);
    expect_val("r5_nb_stored", SNbRsData, 32'h1234);
    // Asynchronous reset mid-run.
    next_cycle(); rst_n = 1'b0;
    expect_val("async_rst_r5", SRsData, 32'h0);
    expect_val("async_rst_nb_r5", SNbRsData, 32'h0);
    expect_val("async_rst_count", SCount, 32'h0);
    next_cycle(); rst_n = 1'b1;

    // Register 0 ignores writes and pend_set.
    next_cycle(); we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF;
    pend_set = 1'b1; pend_addr = 5'd0; rs_addr = 5'd0;
    expect_val("r0_bypass", SRsData, 32'h0);
    expect_val("r0_busy_pre", SRsBusy, 32'h0);
    next_cycle();
    expect_val("r0_read", SRsData, 32'h0);
    expect_val("r0_nb_read", SNbRsData, 32'h0);
    expect_val("r0_busy", SRsBusy, 32'h0);
    expect_val("r0_count", SCount, 32'h0);

    // Bypass on R7.
    next_cycle(); we = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5_A5A5; rs_addr = 5'd7;
    expect_val("r7_bypass", SRsData, 32'hA5A5_A5A5);
    expect_val("r7_nb_old", SNbRsData, 32'h0);
    next_cycle();
    expect_val("r7_nb_new", SNbRsData, 32'hA5A5_A5A5);

    // Collision on R31: link wins.
    next_cycle(); we = 1'b1; rd_addr = 5'd31; rd_data = 32'h11;
    ra_we = 1'b1; ra_data = 32'h400; rs_addr = 5'd31;
    expect_val("r31_coll_bypass", SRsData, 32'h400);
    expect_val("r31_coll_nb_old", SNbRsData, 32'h0);
    next_cycle();
    expect_val("r31_coll", SRsData, 32'h400);
    expect_val("r31_coll_nb", SNbRsData, 32'h400);
    // Dual write: R8 and R31 together.
    next_cycle(); we = 1'b1; rd_addr = 5'd8; rd_data = 32'h88;
    ra_we = 1'b1; ra_data = 32'h800; rs_addr = 5'd8; rt_addr = 5'd31;
    expect_val("dual_rs_bypass", SRsData, 32'h88);
    expect_val("dual_rt_bypass", SRtData, 32'h800);
    expect_val("dual_nb_rs_old", SNbRsData, 32'h0);
    expect_val("dual_nb_rt_old", SNbRtData, 32'h400);
    next_cycle();
    expect_val("dual_r8", SNbRsData, 32'h88);
    expect_val("dual_r31", SNbRtData, 32'h800);

    // Scoreboard on R9.
    next_cycle(); pend_set = 1'b1; pend_addr = 5'd9; rt_addr = 5'd9;
    expect_val("p9_pre_busy", SRtBusy, 32'h0);
    expect_val("p9_pre_count", SCount, 32'h0);
    next_cycle(); pend_set = 1'b1; pend_addr = 5'd9;
    we = 1'b1; rd_addr = 5'd9; rd_data = 32'h99;
    expect_val("p9_busy_hidden", SRtBusy, 32'h0);
    expect_val("p9_nb_busy", SNbRtBusy, 32'h1);
    expect_val("p9_count", SCount, 32'h1);
    expect_val("p9_bypass", SRtData, 32'h99);
    next_cycle();
    expect_val("p9_set_wins_busy", SRtBusy, 32'h1);
    expect_val("p9_set_wins_count", SCount, 32'h1);
    expect_val("p9_r9", SNbRtData, 32'h99);
    next_cycle(); we = 1'b1; rd_addr = 5'd9; rd_data = 32'h9A;
    expect_val("p9_ret_busy", SRtBusy, 32'h0);
    expect_val("p9_ret_nb_busy", SNbRtBusy, 32'h1);
    next_cycle();
    expect_val("p9_clear_busy", SRtBusy, 32'h0);
    expect_val("p9_clear_nb_busy", SNbRtBusy, 32'h0);
    expect_val("p9_clear_count", SCount, 32'h0);

    // Flush overrides a same-cycle set.
    next_cycle(); pend_set = 1'b1; pend_addr = 5'd3;
    next_cycle(); pend_set = 1'b1; pend_addr = 5'd4;
    expect_val("fl_count1", SCount, 32'h1);
    next_cycle(); pend_set = 1'b1; pend_addr = 5'd5;
    expect_val("fl_count2", SCount, 32'h2);
    next_cycle(); flush = 1'b1; pend_set = 1'b1; pend_addr = 5'd6;
    rs_addr = 5'd3; rt_addr = 5'd5;
    expect_val("fl_count3", SCount, 32'h3);
    expect_val("fl_rs_busy_pre", SRsBusy, 32'h1);
    expect_val("fl_rt_busy_pre", SRtBusy, 32'h1);
    next_cycle(); rt_addr = 5'd6;
    expect_val("fl_count0", SCount, 32'h0);
    expect_val("fl_nb_count0", SNbCount, 32'h0);
    expect_val("fl_rs_busy", SRsBusy, 32'h0);
    expect_val("fl_rt6_busy", SRtBusy, 32'h0);

    next_cycle();
    next_cycle();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d checks left unsampled, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
